// File: rtl/word_lit_pkg.sv
// Shared literals and state encoding for the word packer/unpacker pair.
// Holds the transmit FSM state enum and the default word-literal mask.
package word_lit_pkg;

    // Word literal XORed by the packer; the unpacker applies it again to undo it.
    localparam logic [15:0] DEFAULT_MASK = 16'h0001;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } tx_state_t;

endpackage

// File: rtl/word_unpack_tx.sv
// word_unpack_tx: unmasks 16-bit words and emits them as two bytes.
// Ports: clk, rst (async active-low); upstream in_valid/in_data/in_ready;
// downstream out_valid/out_data/out_last/out_ready; words_done counter.
module word_unpack_tx
    import word_lit_pkg::*;
#(
    parameter logic [15:0] MASK      = DEFAULT_MASK,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic [15:0] words_done
);

    tx_state_t   state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] words_q, words_d;
    logic        accept;
    logic [7:0]  first_byte;
    logic [7:0]  second_byte;

    // A new word may load on the same edge the second byte leaves,
    // which is what makes back-to-back words bubble-free.
    assign in_ready = (state_q == EMPTY) ||
                      ((state_q == SECOND) && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        words_d = words_q;
        if (accept) begin
            hold_d = in_data ^ MASK;
        end
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FIRST;
                end
            end
            FIRST: begin
                if (out_ready) begin
                    state_d = SECOND;
                end
            end
            SECOND: begin
                if (out_ready) begin
                    words_d = words_q + 16'd1;
                    state_d = accept ? FIRST : EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            hold_q  <= 16'h0000;
            words_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            words_q <= words_d;
        end
    end

    // Outputs depend only on registered state, so they stay put under stall.
    assign first_byte  = MSB_FIRST ? hold_q[15:8] : hold_q[7:0];
    assign second_byte = MSB_FIRST ? hold_q[7:0]  : hold_q[15:8];

    assign out_valid  = (state_q != EMPTY);
    assign out_last   = (state_q == SECOND);
    assign out_data   = out_last ? second_byte : first_byte;
    assign words_done = words_q;

endmodule

// File: tb/tb_word_unpack_tx.sv
// Testbench for word_unpack_tx: MSB-first and LSB-first instances share
// stimulus and are checked against a byte-queue reference model.
module tb_word_unpack_tx;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } byte_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_last;
    logic [7:0]  out_data;
    logic [15:0] words_done;
    logic        in_ready_l, out_valid_l, out_last_l;
    logic [7:0]  out_data_l;
    logic [15:0] words_done_l;

    int checks = 0;
    int errors = 0;

    byte_t       qm[$];
    byte_t       ql[$];
    logic [15:0] wc = 16'h0000;

    always #5 clk = ~clk;

    word_unpack_tx #(.MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last),
        .words_done(words_done)
    );

    word_unpack_tx #(.MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_l),
        .out_ready(out_ready), .out_valid(out_valid_l),
        .out_data(out_data_l), .out_last(out_last_l),
        .words_done(words_done_l)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check pre-edge outputs against the model, advance.
    task automatic tick(input logic v, input logic [15:0] d,
                        input logic r);
        logic        er;
        logic [15:0] w;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #2;
        er = (qm.size() == 0) || ((qm.size() == 1) && r);
        chk("in_ready", {15'd0, in_ready}, {15'd0, er});
        chk("in_ready_l", {15'd0, in_ready_l}, {15'd0, er});
        chk("out_valid", {15'd0, out_valid}, {15'd0, qm.size() != 0});
        chk("out_valid_l", {15'd0, out_valid_l}, {15'd0, ql.size() != 0});
        if (qm.size() != 0) begin
            chk("out_data", {8'd0, out_data}, {8'd0, qm[0].d});
            chk("out_last", {15'd0, out_last}, {15'd0, qm[0].l});
            chk("out_data_l", {8'd0, out_data_l}, {8'd0, ql[0].d});
            chk("out_last_l", {15'd0, out_last_l}, {15'd0, ql[0].l});
        end
        chk("words_done", words_done, wc);
        chk("words_done_l", words_done_l, wc);
        @(posedge clk);
        #1;
        if (r && (qm.size() != 0)) begin
            if (qm[0].l) wc = wc + 16'd1;
            void'(qm.pop_front());
            void'(ql.pop_front());
        end
        if (v && er) begin
            w = d ^ 16'h0001;
            qm.push_back('{w[15:8], 1'b0});
            qm.push_back('{w[7:0], 1'b1});
            ql.push_back('{w[7:0], 1'b0});
            ql.push_back('{w[15:8], 1'b1});
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_out_last", {15'd0, out_last}, 16'd0);
        chk("rst_out_data", {8'd0, out_data}, 16'd0);
        chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
        chk("rst_words", words_done, 16'd0);
        chk("rst_words_l", words_done_l, 16'd0);
    endtask

    initial begin
        #3;
        chk_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single word, MSB instance 12,34 and LSB instance CC?-style order
        tick(1'b1, 16'h1235, 1'b1);
        tick(1'b0, 16'h0000, 1'b1);
        tick(1'b0, 16'h0000, 1'b1);
        chk("one_word_count", words_done, 16'd1);

        // LSB-first ordering: ABCD -> CC then AB
        tick(1'b1, 16'hABCD, 1'b1);
        tick(1'b0, 16'h0000, 1'b1);
        tick(1'b0, 16'h0000, 1'b1);

        // Three back-to-back words, no gaps
        tick(1'b1, 16'h1111, 1'b1);
        tick(1'b1, 16'h2222, 1'b1);
        tick(1'b1, 16'h3333, 1'b1);
        tick(1'b1, 16'h4444, 1'b1);
        tick(1'b1, 16'h5555, 1'b1);
        tick(1'b0, 16'h0000, 1'b1);
        tick(1'b0, 16'h0000, 1'b1);
        chk("b2b_count", words_done, 16'd5);

        // Stall in FIRST with a competing word offered
        tick(1'b1, 16'h7E81, 1'b1);
        repeat (5) tick(1'b1, 16'hDEAD, 1'b0);
        tick(1'b0, 16'h0000, 1'b1);
        tick(1'b0, 16'h0000, 1'b1);
        tick(1'b0, 16'h0000, 1'b1);

        // Reset while in SECOND
        tick(1'b1, 16'h5A5B, 1'b1);
        tick(1'b0, 16'h0000, 1'b1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs();
        qm.delete();
        ql.delete();
        wc = 16'h0000;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        tick(1'b1, 16'hC3C4, 1'b1);
        tick(1'b0, 16'h0000, 1'b1);
        tick(1'b0, 16'h0000, 1'b1);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            tick(1'($urandom_range(0, 1)), 16'($urandom),
                 1'($urandom_range(0, 3) != 0));
        end
        repeat (4) tick(1'b0, 16'h0000, 1'b1);

        // Counter wrap from FFFF
        force dut.words_q = 16'hFFFF;
        force dut_l.words_q = 16'hFFFF;
        #1;
        release dut.words_q;
        release dut_l.words_q;
        wc = 16'hFFFF;
        tick(1'b1, 16'h0F0F, 1'b1);
        tick(1'b0, 16'h0000, 1'b1);
        tick(1'b0, 16'h0000, 1'b1);
        chk("wrap_count", words_done, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
